// File: rtl/pwm_ramp_controller.sv
// Soft-start/soft-stop sequencer for a pwm_generator: walks the generator threshold
// toward a target in bounded steps, loading new values only at period boundaries.
module pwm_ramp_controller #(
   parameter int n_bit     = 8,
   parameter int dwell_bit = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 start,
   input  logic                 abort,
   input  logic [n_bit-1:0]     target,
   input  logic [n_bit-1:0]     step,
   input  logic [dwell_bit-1:0] dwell,
   input  logic [n_bit-1:0]     pwm_count,
   output logic                 pwm_enable,
   output logic                 pwm_load,
   output logic [n_bit-1:0]     pwm_threshold,
   output logic [n_bit-1:0]     current,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_LOAD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [n_bit-1:0]     COUNT_MAX = {n_bit{1'b1}};
   localparam logic [n_bit-1:0]     STEP_ONE  = {{(n_bit-1){1'b0}}, 1'b1};
   localparam logic [dwell_bit-1:0] DWELL_ONE = {{(dwell_bit-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [n_bit-1:0]     current_q, current_d;
   logic [n_bit-1:0]     thr_q, thr_d;
   logic [n_bit-1:0]     tgt_q, tgt_d;
   logic [n_bit-1:0]     step_q, step_d;
   logic [dwell_bit-1:0] dwell_q, dwell_d;
   logic [dwell_bit-1:0] cnt_q, cnt_d;
   logic                 boundary_s;

   // Move cur toward tgt by stp in n_bit+1 bits, clamping at tgt so it never overshoots or wraps.
   function automatic logic [n_bit-1:0] step_toward(input logic [n_bit-1:0] cur,
                                                    input logic [n_bit-1:0] tgt,
                                                    input logic [n_bit-1:0] stp);
      logic [n_bit:0] wide;
      logic [n_bit-1:0] res;
      if (tgt > cur) begin
         wide = {1'b0, cur} + {1'b0, stp};
         res  = (wide >= {1'b0, tgt}) ? tgt : wide[n_bit-1:0];
      end else begin
         wide = {1'b0, cur} - {1'b0, stp};
         res  = (wide[n_bit] || (wide[n_bit-1:0] <= tgt)) ? tgt : wide[n_bit-1:0];
      end
      return res;
   endfunction

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         current_q <= {n_bit{1'b0}};
         thr_q     <= {n_bit{1'b0}};
         tgt_q     <= {n_bit{1'b0}};
         step_q    <= {n_bit{1'b0}};
         dwell_q   <= {dwell_bit{1'b0}};
         cnt_q     <= {dwell_bit{1'b0}};
      end else begin
         state_q   <= state_d;
         current_q <= current_d;
         thr_q     <= thr_d;
         tgt_q     <= tgt_d;
         step_q    <= step_d;
         dwell_q   <= dwell_d;
         cnt_q     <= cnt_d;
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_d   = state_q;
      current_d = current_q;
      thr_d     = thr_q;
      tgt_d     = tgt_q;
      step_d    = step_q;
      dwell_d   = dwell_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               tgt_d   = target;
               step_d  = (step == {n_bit{1'b0}}) ? STEP_ONE : step;
               dwell_d = dwell;
               cnt_d   = {dwell_bit{1'b0}};
               state_d = (target == current_q) ? S_DONE : S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (abort) begin
               cnt_d   = {dwell_bit{1'b0}};
               state_d = S_IDLE;
            end else if (boundary_s) begin
               if (cnt_q == dwell_q) begin
                  thr_d   = step_toward(current_q, tgt_q, step_q);
                  state_d = S_LOAD;
               end else begin
                  cnt_d = cnt_q + DWELL_ONE;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_LOAD: begin
            current_d = thr_q;
            cnt_d     = {dwell_bit{1'b0}};
            state_d   = (thr_q == tgt_q) ? S_DONE : S_RUN;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state; the generator counter is frozen during the load cycle.
   always_comb begin
      pwm_enable    = enable & reset & (state_q != S_LOAD);
      boundary_s    = pwm_enable & (pwm_count == COUNT_MAX);
      pwm_load      = (state_q == S_LOAD);
      pwm_threshold = thr_q;
      current       = current_q;
      busy          = (state_q == S_RUN) || (state_q == S_LOAD);
      done          = (state_q == S_DONE);
   end

endmodule
